beam_scan_controller: RTL

//  Sequences the 8-mic delay block's delay_select to scan candidate steering directions.
//  Per direction: waits for the delay lines to flush, then integrates |beamformed sum| over a window.

---
 rtl/beam_scan_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/beam_scan_controller.sv
// Beam scan controller: steps delay_select through the candidate directions, integrates
// |beamformed sum| per direction after a flush period, and locks onto the most energetic one.
module beam_scan_controller #(
    parameter int unsigned NUM_DIRS       = 3,
    parameter int unsigned SETTLE_SAMPLES = 16,
    parameter int unsigned WINDOW_LOG2    = 8,
    parameter int unsigned DATA_W         = 22,
    parameter int unsigned ACC_W          = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sum_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     manual_we,
    input  logic        [4:0]        manual_dir,
    output logic        [4:0]        delay_select,
    output logic                     busy,
    output logic                     done,
    output logic        [4:0]        best_dir,
    output logic        [ACC_W-1:0]  best_energy
);

    localparam int unsigned DIR_W   = 5;
    localparam int unsigned WIN     = 1 << WINDOW_LOG2;
    localparam int unsigned CNT_MAX = (SETTLE_SAMPLES > WIN) ? SETTLE_SAMPLES : WIN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ABS_W   = DATA_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_COMPARE,
        S_LOCK
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [DIR_W-1:0]   r_cur_dir;
    logic [DIR_W-1:0]   r_run_dir;
    logic [ACC_W-1:0]   r_run_energy;
    logic [DIR_W-1:0]   r_delay;
    logic               r_busy;
    logic               r_done;
    logic [DIR_W-1:0]   r_best_dir;
    logic [ACC_W-1:0]   r_best_energy;

    logic [ABS_W-1:0]   w_abs;
    logic               w_take;
    logic [DIR_W-1:0]   w_win_dir;
    logic [ACC_W-1:0]   w_win_energy;
    logic               w_last_dir;
    logic               w_manual_ok;

    // Magnitude of the sum; the most-negative code clamps to the largest positive magnitude.
    always_comb begin
        w_abs = sum_data[ABS_W-1:0];
        if (sum_data[DATA_W-1]) begin
            if (sum_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
                w_abs = '1;
            end else begin
                w_abs = ABS_W'(-sum_data);
            end
        end
    end

    // Direction 0 always seeds the running best; later ones must be strictly larger.
    assign w_take       = (r_acc > r_run_energy) || (r_cur_dir == '0);
    assign w_win_dir    = w_take ? r_cur_dir : r_run_dir;
    assign w_win_energy = w_take ? r_acc : r_run_energy;
    assign w_last_dir   = (r_cur_dir == DIR_W'(NUM_DIRS - 1));
    assign w_manual_ok  = manual_we && ({1'b0, manual_dir} < 6'(NUM_DIRS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_cur_dir     <= '0;
            r_run_dir     <= '0;
            r_run_energy  <= '0;
            r_delay       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_best_dir    <= '0;
            r_best_energy <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_LOCK: begin
                        if (start) begin
                            r_state      <= S_SETTLE;
                            r_busy       <= 1'b1;
                            r_cnt        <= '0;
                            r_cur_dir    <= '0;
                            r_delay      <= '0;
                            r_run_dir    <= '0;
                            r_run_energy <= '0;
                        end else if (w_manual_ok) begin
                            r_delay <= manual_dir;
                        end
                    end
                    S_SETTLE: begin
                        if (sample_valid) begin
                            if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                                r_state <= S_ACCUM;
                                r_cnt   <= '0;
                                r_acc   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (sample_valid) begin
                            r_acc <= r_acc + ACC_W'(w_abs);
                            if (r_cnt == CNT_W'(WIN - 1)) begin
                                r_state <= S_COMPARE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_COMPARE: begin
                        r_run_dir    <= w_win_dir;
                        r_run_energy <= w_win_energy;
                        if (!w_last_dir) begin
                            r_cur_dir <= r_cur_dir + 1'b1;
                            r_delay   <= r_cur_dir + 1'b1;
                            r_state   <= S_SETTLE;
                        end else begin
                            r_state       <= S_LOCK;
                            r_busy        <= 1'b0;
                            r_delay       <= w_win_dir;
                            r_best_dir    <= w_win_dir;
                            r_best_energy <= w_win_energy;
                            r_done        <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign delay_select = r_delay;
    assign busy         = r_busy;
    assign done         = r_done;
    assign best_dir     = r_best_dir;
    assign best_energy  = r_best_energy;

endmodule
